// File: rtl/uart_loader_if.sv
// uart_loader_if: receiver byte stream in, instruction-memory write port out.
interface uart_loader_if #(parameter int ADDR_W = 15);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    modport master (output rx_valid, rx_data, input imem_we, imem_addr, imem_wdata);
    modport slave  (input rx_valid, rx_data, output imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/uart_loader.sv
// uart_loader: parses a length-prefixed big-endian word image from UART bytes
// and writes it to instruction memory, raising done when complete.
module uart_loader #(
    parameter int ADDR_W    = 15,
    parameter int BASE_ADDR = 0
) (
    input  logic            clk,
    input  logic            rstn,
    uart_loader_if.slave    bus,
    input  logic            restart,
    output logic            loading,
    output logic            done,
    output logic            err,
    output logic [ADDR_W:0] words_written
);
    typedef enum logic [1:0] {S_HDR, S_DATA, S_DONE, S_ERR} state_t;

    localparam logic [32:0]       LIM  = (33'd1 << ADDR_W) - 33'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE  = (ADDR_W+1)'(1);

    state_t            state_q, state_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [31:0]       sh_q, sh_d, byte_sh;
    logic [ADDR_W:0]   remain_q, remain_d, ww_q, ww_d;
    logic              we_q, we_d, loading_q, loading_d, done_q, done_d, err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    always_comb begin
        state_d   = state_q;
        bidx_d    = bidx_q;
        sh_d      = sh_q;
        remain_d  = remain_q;
        ww_d      = ww_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        loading_d = loading_q;
        done_d    = done_q;
        err_d     = err_q;
        byte_sh   = 32'({sh_q, bus.rx_data});
        if (restart) begin
            // restart wins over a coincident byte, which is dropped
            state_d   = S_HDR;
            bidx_d    = '0;
            sh_d      = '0;
            remain_d  = '0;
            ww_d      = '0;
            addr_d    = '0;
            wdata_d   = '0;
            loading_d = 1'b0;
            done_d    = 1'b0;
            err_d     = 1'b0;
        end else if (bus.rx_valid && (state_q == S_HDR || state_q == S_DATA)) begin
            sh_d      = byte_sh;
            bidx_d    = bidx_q + 2'd1;
            loading_d = 1'b1;
            if (bidx_q == 2'd3 && state_q == S_HDR) begin
                if (byte_sh == 32'd0) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    loading_d = 1'b0;
                end else if ({1'b0, byte_sh} > LIM) begin
                    state_d   = S_ERR;
                    err_d     = 1'b1;
                    loading_d = 1'b0;
                end else begin
                    remain_d = byte_sh[ADDR_W:0];
                    state_d  = S_DATA;
                end
            end else if (bidx_q == 2'd3) begin
                we_d     = 1'b1;
                wdata_d  = byte_sh;
                addr_d   = BASE + ww_q[ADDR_W-1:0];
                ww_d     = ww_q + ONE;
                remain_d = remain_q - ONE;
                if (remain_q == ONE) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    loading_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_HDR;
            bidx_q    <= '0;
            sh_q      <= '0;
            remain_q  <= '0;
            ww_q      <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            loading_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bidx_q    <= bidx_d;
            sh_q      <= sh_d;
            remain_q  <= remain_d;
            ww_q      <= ww_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            loading_q <= loading_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign loading        = loading_q;
    assign done           = done_q;
    assign err            = err_q;
    assign words_written  = ww_q;
endmodule

// File: tb/tb_uart_loader.sv
// tb_uart_loader: directed and randomized images against a byte-level reference model.
module tb_uart_loader;
    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        restart0 = 1'b0, restart1 = 1'b0;
    logic        loading0, done0, err0, loading1, done1, err1;
    logic [15:0] ww0;
    logic [4:0]  ww1;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_loader_if #(.ADDR_W(15)) b0 ();
    uart_loader_if #(.ADDR_W(4))  b1 ();

    uart_loader #(.ADDR_W(15), .BASE_ADDR(0)) u0 (
        .clk(clk), .rstn(rstn), .bus(b0.slave), .restart(restart0),
        .loading(loading0), .done(done0), .err(err0), .words_written(ww0)
    );
    uart_loader #(.ADDR_W(4), .BASE_ADDR(8)) u1 (
        .clk(clk), .rstn(rstn), .bus(b1.slave), .restart(restart1),
        .loading(loading1), .done(done1), .err(err1), .words_written(ww1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] b);
        if (d == 0) begin
            b0.rx_valid = v;
            b0.rx_data  = b;
        end else begin
            b1.rx_valid = v;
            b1.rx_data  = b;
        end
    endtask

    task automatic sample(input int d, output logic we, output logic [31:0] addr,
                          output logic [31:0] data, output logic ld, output logic dn,
                          output logic er, output logic [31:0] ww);
        if (d == 0) begin
            we = b0.imem_we; addr = 32'(b0.imem_addr); data = b0.imem_wdata;
            ld = loading0; dn = done0; er = err0; ww = 32'(ww0);
        end else begin
            we = b1.imem_we; addr = 32'(b1.imem_addr); data = b1.imem_wdata;
            ld = loading1; dn = done1; er = err1; ww = 32'(ww1);
        end
    endtask

    function automatic logic [31:0] wd(bytes_t q, int k);
        return {q[k], q[k+1], q[k+2], q[k+3]};
    endfunction

    task automatic chk_idle(input int d, input string tag);
        logic we, ld, dn, er;
        logic [31:0] addr, data, ww;
        sample(d, we, addr, data, ld, dn, er, ww);
        chk({tag, " we"}, we, 0);
        chk({tag, " loading"}, ld, 0);
        chk({tag, " done"}, dn, 0);
        chk({tag, " err"}, er, 0);
        chk({tag, " words"}, ww, 0);
    endtask

    // Feeds a fresh load byte by byte; after each byte the model predicts every output.
    task automatic send_seq(input int d, input bytes_t q, input int gap, input string tag);
        int     aw   = (d == 0) ? 15 : 4;
        longint base = (d == 0) ? 0 : 8;
        longint lim  = (longint'(1) << aw) - base;
        longint n    = longint'(wd(q, 0));
        bit     ok   = (n != 0) && (n <= lim);
        for (int j = 0; j < q.size(); j++) begin
            logic we, ld, dn, er;
            logic [31:0] addr, data, ww;
            longint wi, eww;
            bit ewr, edn, eer;
            drive(d, 1'b1, q[j]);
            @(negedge clk);
            drive(d, 1'b0, 8'h00);
            wi  = (j >= 4) ? (j - 4) / 4 : 0;
            ewr = ok && j >= 4 && (j % 4) == 3 && wi < n;
            edn = j >= 3 && (n == 0 || (ok && j >= 3 + 4 * n));
            eer = j >= 3 && n > lim;
            eww = (ok && j >= 7) ? (((j - 3) / 4 < n) ? (j - 3) / 4 : n) : 0;
            sample(d, we, addr, data, ld, dn, er, ww);
            chk({tag, " we"}, we, ewr);
            if (ewr) begin
                chk({tag, " addr"}, addr, base + wi);
                chk({tag, " data"}, data, wd(q, j - 3));
            end
            chk({tag, " words"}, ww, eww);
            chk({tag, " done"}, dn, edn);
            chk({tag, " err"}, er, eer);
            chk({tag, " loading"}, ld, !edn && !eer);
            if (gap > 0) begin
                @(negedge clk);
                sample(d, we, addr, data, ld, dn, er, ww);
                chk({tag, " we pulse"}, we, 0);
                repeat (gap - 1) @(negedge clk);
            end
        end
    endtask

    task automatic do_restart(input int d, input logic v, input logic [7:0] b, input string tag);
        if (d == 0) restart0 = 1'b1; else restart1 = 1'b1;
        drive(d, v, b);
        @(negedge clk);
        restart0 = 1'b0;
        restart1 = 1'b0;
        drive(d, 1'b0, 8'h00);
        chk_idle(d, tag);
    endtask

    function automatic bytes_t image(input logic [31:0] n, input int words, input int extra);
        bytes_t q;
        for (int i = 0; i < 4; i++) q.push_back(n[31-8*i -: 8]);
        for (int i = 0; i < 4 * words + extra; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bytes_t q;
        logic we, ld, dn, er;
        logic [31:0] addr, data, ww;
        int n;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            sample(d, we, addr, data, ld, dn, er, ww);
            chk("reset addr", addr, 0);
            chk("reset data", data, 0);
            chk_idle(d, "reset");
        end
        rstn = 1'b1;
        @(negedge clk);

        q = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        send_seq(0, q, 10, "spaced");
        do_restart(0, 1'b0, 8'h00, "rs1");
        send_seq(0, q, 0, "b2b");
        do_restart(0, 1'b0, 8'h00, "rs2");

        send_seq(0, image(32'd0, 0, 6), 0, "zero");
        do_restart(0, 1'b0, 8'h00, "rs3");

        n = int'($urandom_range(1, 5));
        send_seq(0, image(32'(n), n, 8), int'($urandom_range(0, 2)), "rand_extra");
        repeat (5) @(negedge clk);
        sample(0, we, addr, data, ld, dn, er, ww);
        chk("done sticky", dn, 1);
        do_restart(0, 1'b0, 8'h00, "rs4");

        send_seq(1, image(32'd9, 0, 4), 0, "small_err");
        do_restart(1, 1'b0, 8'h00, "rs5");
        send_seq(1, image(32'h01000000, 0, 0), 1, "big_err");
        do_restart(1, 1'b0, 8'h00, "rs6");
        send_seq(1, image(32'd8, 8, 4), 0, "small_full");
        do_restart(1, 1'b0, 8'h00, "rs7");
        send_seq(1, image(32'd3, 3, 0), 0, "small_three");
        do_restart(1, 1'b0, 8'h00, "rs8");

        send_seq(0, image(32'd3, 1, 2), 0, "mid_a");
        do_restart(0, 1'b1, 8'h5A, "rs_byte");
        send_seq(0, image(32'd3, 3, 0), int'($urandom_range(0, 1)), "fresh_a");
        do_restart(0, 1'b0, 8'h00, "rs9");

        send_seq(0, image(32'd3, 1, 2), 0, "mid_b");
        #2 rstn = 1'b0;
        #1;
        sample(0, we, addr, data, ld, dn, er, ww);
        chk("async addr", addr, 0);
        chk("async data", data, 0);
        chk_idle(0, "async");
        rstn = 1'b1;
        @(negedge clk);
        send_seq(0, image(32'd3, 3, 0), 0, "fresh_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
